// File: rtl/rst_seq_ctrl_if.sv
// Signal bundle between the reset sequencer and the reset generator / downstream subsystems.
// master is the sequencer side; slave is the generator/environment side.
interface rst_seq_ctrl_if #(
    parameter int unsigned STAGES = 3
);
    logic              IR_N;
    logic              SRST_REQ;
    logic              ENIR;
    logic [STAGES-1:0] STG_RST_N;
    logic              READY;
    logic              SRST_ACK;

    modport master (
        input  IR_N,
        input  SRST_REQ,
        output ENIR,
        output STG_RST_N,
        output READY,
        output SRST_ACK
    );

    modport slave (
        output IR_N,
        output SRST_REQ,
        input  ENIR,
        input  STG_RST_N,
        input  READY,
        input  SRST_ACK
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Power-up / soft-reset sequencer: paces the reset generator enable, waits for IR_N release,
// then releases the staged subsystem resets one by one with a tick-based gap.
module rst_seq_ctrl #(
    parameter int unsigned PRESC     = 4000,
    parameter int unsigned STAGES    = 3,
    parameter int unsigned STAGE_GAP = 2,
    parameter int unsigned SOFT_HOLD = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    rst_seq_ctrl_if.master seq
);

    localparam int unsigned CNT_W  = (PRESC > 1)     ? $clog2(PRESC)     : 1;
    localparam int unsigned GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int unsigned HOLD_W = $clog2(SOFT_HOLD + 1);
    localparam int unsigned K_W    = (STAGES > 1)    ? $clog2(STAGES)    : 1;

    localparam logic [1:0] S_WAIT_IR = 2'd0;
    localparam logic [1:0] S_RELEASE = 2'd1;
    localparam logic [1:0] S_RUN     = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    logic [CNT_W-1:0]  cnt_q;
    logic              tick_c;

    logic [1:0]        state_q,  state_d;
    logic [GAP_W-1:0]  gap_q,    gap_d;
    logic [HOLD_W-1:0] hold_q,   hold_d;
    logic [K_W-1:0]    k_q,      k_d;
    logic [STAGES-1:0] stg_q,    stg_d;
    logic              ready_q,  ready_d;
    logic              ack_q,    ack_d;

    // Free-running prescaler; runs in every state so tick phase is fixed relative to reset release.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (tick_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick_c = (cnt_q == CNT_W'(PRESC - 1));

    // State and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_WAIT_IR;
            gap_q   <= '0;
            hold_q  <= '0;
            k_q     <= '0;
            stg_q   <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            hold_q  <= hold_d;
            k_q     <= k_d;
            stg_q   <= stg_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state logic; a generator drop outranks a soft-reset request.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        k_d     = k_q;
        stg_d   = stg_q;
        ready_d = ready_q;
        ack_d   = 1'b0;

        if ((state_q != S_WAIT_IR) && !seq.IR_N) begin
            state_d = S_WAIT_IR;
            stg_d   = '0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                S_WAIT_IR: begin
                    if (seq.IR_N) begin
                        state_d = S_RELEASE;
                        gap_d   = '0;
                        k_d     = '0;
                    end
                end
                S_RELEASE, S_RUN: begin
                    if (seq.SRST_REQ) begin
                        state_d = S_HOLD;
                        hold_d  = '0;
                        stg_d   = '0;
                        ready_d = 1'b0;
                        ack_d   = 1'b1;
                    end else if ((state_q == S_RELEASE) && tick_c) begin
                        if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
                            gap_d      = '0;
                            stg_d[k_q] = 1'b1;
                            if (k_q == K_W'(STAGES - 1)) begin
                                ready_d = 1'b1;
                                state_d = S_RUN;
                            end else begin
                                k_d = k_q + K_W'(1);
                            end
                        end else begin
                            gap_d = gap_q + GAP_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    // Exit needs both the minimum hold and a released request.
                    if ((hold_q == HOLD_W'(SOFT_HOLD)) && !seq.SRST_REQ) begin
                        state_d = S_RELEASE;
                        gap_d   = '0;
                        k_d     = '0;
                    end else if (tick_c && (hold_q != HOLD_W'(SOFT_HOLD))) begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                default: begin
                    state_d = S_WAIT_IR;
                end
            endcase
        end
    end

    assign seq.ENIR      = (state_q == S_WAIT_IR) && tick_c;
    assign seq.STG_RST_N = stg_q;
    assign seq.READY     = ready_q;
    assign seq.SRST_ACK  = ack_q;

endmodule
